// File: rtl/hist_frame_summarizer.sv
// Reduces each 64-bin histogram frame to {total, peak index, peak value} and emits it as a byte record.
// Define HIST_SUM_CHECKSUM_EN to append an XOR checksum byte (5-byte record instead of 4).
module hist_frame_summarizer #(
    parameter int NUM_BINS = 64,
    parameter int BIN_W    = 4,
    parameter int IDX_W    = 6,
    parameter int SUM_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bin_valid,
    input  logic [BIN_W-1:0] bin_data,
    input  logic             bin_last,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [7:0]       sum_byte,
    output logic             sum_first,
    output logic             sum_last,
    output logic             busy,
    output logic             frame_err
);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_EMIT    = 1'b1;
`ifdef HIST_SUM_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX  = 3'd4;
`else
    localparam logic [2:0] LAST_IDX  = 3'd3;
`endif
    localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(NUM_BINS);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(NUM_BINS - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W:0]   beat_cnt_q, beat_cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [BIN_W-1:0] max_val_q, max_val_d;
    logic [IDX_W-1:0] max_idx_q, max_idx_d;
    logic             err_pending_q, err_pending_d;
    logic             drop_pending_q, drop_pending_d;
    logic             rec_err_q, rec_err_d;
    logic             rec_drop_q, rec_drop_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             frame_err_q, frame_err_d;
    logic             close;
    logic             close_err;

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        sum_d          = sum_q;
        max_val_d      = max_val_q;
        max_idx_d      = max_idx_q;
        err_pending_d  = err_pending_q;
        drop_pending_d = drop_pending_q;
        rec_err_d      = rec_err_q;
        rec_drop_d     = rec_drop_q;
        byte_idx_d     = byte_idx_q;
        frame_err_d    = 1'b0;
        close          = 1'b0;
        close_err      = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (bin_valid) begin
                    if (err_pending_q) begin
                        // Overlong frame: extra beats are ignored until last closes it
                        if (bin_last) begin
                            close     = 1'b1;
                            close_err = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = (beat_cnt_q == CNT_FULL) ? beat_cnt_q : beat_cnt_q + 1'b1;
                        sum_d      = sum_q + SUM_W'(bin_data);
                        if (bin_data > max_val_q) begin
                            max_val_d = bin_data;
                            max_idx_d = beat_cnt_q[IDX_W-1:0];
                        end
                        if (bin_last) begin
                            close     = 1'b1;
                            close_err = (beat_cnt_q != CNT_LAST);
                        end else if (beat_cnt_q == CNT_LAST) begin
                            err_pending_d = 1'b1;
                        end
                    end
                end
                if (close) begin
                    state_d        = S_EMIT;
                    rec_err_d      = close_err;
                    // The pending drop is latched into this record; new drops go to the next one
                    rec_drop_d     = drop_pending_q;
                    drop_pending_d = 1'b0;
                    frame_err_d    = close_err;
                    byte_idx_d     = 3'd0;
                end
            end
            default: begin
                if (bin_valid) drop_pending_d = 1'b1;
                if (sum_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        state_d       = S_COLLECT;
                        beat_cnt_d    = '0;
                        sum_d         = '0;
                        max_val_d     = '0;
                        max_idx_d     = '0;
                        err_pending_d = 1'b0;
                        byte_idx_d    = 3'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_COLLECT;
            beat_cnt_q     <= '0;
            sum_q          <= '0;
            max_val_q      <= '0;
            max_idx_q      <= '0;
            err_pending_q  <= 1'b0;
            drop_pending_q <= 1'b0;
            rec_err_q      <= 1'b0;
            rec_drop_q     <= 1'b0;
            byte_idx_q     <= 3'd0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            sum_q          <= sum_d;
            max_val_q      <= max_val_d;
            max_idx_q      <= max_idx_d;
            err_pending_q  <= err_pending_d;
            drop_pending_q <= drop_pending_d;
            rec_err_q      <= rec_err_d;
            rec_drop_q     <= rec_drop_d;
            byte_idx_q     <= byte_idx_d;
            frame_err_q    <= frame_err_d;
        end
    end

    logic [7:0] b0, b1, b2, b3, cur_byte;
    assign b0 = 8'hA5;
    assign b1 = {rec_err_q, rec_drop_q, max_idx_q};
    assign b2 = sum_q[7:0];
    assign b3 = {max_val_q, 2'b00, sum_q[9:8]};

    // Record fields are frozen during EMIT, so muxing from live registers keeps bytes stable under stall
    always_comb begin
        case (byte_idx_q)
            3'd0:    cur_byte = b0;
            3'd1:    cur_byte = b1;
            3'd2:    cur_byte = b2;
            3'd3:    cur_byte = b3;
`ifdef HIST_SUM_CHECKSUM_EN
            3'd4:    cur_byte = b0 ^ b1 ^ b2 ^ b3;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    assign sum_valid = (state_q == S_EMIT);
    assign sum_byte  = sum_valid ? cur_byte : 8'h00;
    assign sum_first = sum_valid && (byte_idx_q == 3'd0);
    assign sum_last  = sum_valid && (byte_idx_q == LAST_IDX);
    assign busy      = (state_q == S_EMIT);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_hist_frame_summarizer.sv
// Directed frames with hand-computed records; a monitor pops expected bytes on each accepted handshake.
module tb_hist_frame_summarizer;

`ifdef HIST_SUM_CHECKSUM_EN
    localparam int REC_LEN = 5;
`else
    localparam int REC_LEN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bin_valid = 1'b0;
    logic [3:0] bin_data = 4'h0;
    logic       bin_last = 1'b0;
    logic       sum_valid;
    logic       sum_ready = 1'b0;
    logic [7:0] sum_byte;
    logic       sum_first;
    logic       sum_last;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int rdy_cnt = 0;
    logic [9:0] exp_q[$];
    logic [3:0] frame_vals[0:127];

    hist_frame_summarizer dut (
        .clk(clk), .rst_n(rst_n),
        .bin_valid(bin_valid), .bin_data(bin_data), .bin_last(bin_last),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_byte(sum_byte),
        .sum_first(sum_first), .sum_last(sum_last),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push_record(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] ck;
        ck = 8'hA5 ^ b1 ^ b2 ^ b3;
        exp_q.push_back({8'hA5, 1'b1, 1'b0});
        exp_q.push_back({b1, 1'b0, 1'b0});
        exp_q.push_back({b2, 1'b0, 1'b0});
`ifdef HIST_SUM_CHECKSUM_EN
        exp_q.push_back({b3, 1'b0, 1'b0});
        exp_q.push_back({ck, 1'b0, 1'b1});
`else
        exp_q.push_back({b3, 1'b0, 1'b1});
        if (ck == 8'h00) checks += 0;
`endif
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bin_valid = 1'b1;
            bin_data  = frame_vals[i];
            bin_last  = (i == n - 1);
        end
        @(posedge clk); #1;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic fill(input int mode, input logic [3:0] v);
        for (int i = 0; i < 128; i++)
            frame_vals[i] = (mode == 1) ? 4'(i % 16) : v;
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !sum_valid) break;
        end
        checks++;
        if (k == 300) begin
            errors++;
            $display("FAIL %s drain timeout: %0d bytes outstanding, sum_valid=%0b", name, exp_q.size(), sum_valid);
            exp_q.delete();
        end else begin
            $display("ok   %s record drained", name);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = three idle cycles per accept
    initial begin
        forever begin
            @(posedge clk); #1;
            rdy_cnt++;
            if (ready_mode == 0) sum_ready = 1'b1;
            else                 sum_ready = (rdy_cnt % 4 == 3);
        end
    end

    // Monitor: compares accepted bytes and checks hold-stability during stalls
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;
    always @(negedge clk) begin
        logic [9:0] got;
        logic [9:0] exp;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            got = {sum_byte, sum_first, sum_last};
            if (prev_stall) begin
                checks++;
                if (!sum_valid || got !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0b/%03h expected=1/%03h", sum_valid, got, prev_out);
                end
            end
            if (sum_valid && sum_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte unexpected actual=%03h expected=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL byte actual={%02h,f%0b,l%0b} expected={%02h,f%0b,l%0b}",
                                 got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
                    end else begin
                        $display("byte %02h first=%0b last=%0b", got[9:2], got[1], got[0]);
                    end
                end
            end
            prev_stall = sum_valid && !sum_ready;
            prev_out   = got;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {24'h0, sum_valid, sum_first, sum_last, busy, frame_err, 3'b0} | {24'h0, sum_byte}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ramp frame i%16: sum 480, peak 15 at index 15, one byte per clock
        fill(1, 4'h0);
        push_record(8'h0F, 8'hE0, 8'hF1);
        send_frame(64);
        chk("lat_valid", {31'h0, sum_valid}, 32'h1);
        chk("lat_b0", {24'h0, sum_byte}, 32'hA5);
        chk("ramp_frame_err", {31'h0, frame_err}, 32'h0);
        for (int k = 1; k < REC_LEN; k++) begin
            @(posedge clk); #1;
            chk("b2b_valid", {31'h0, sum_valid}, 32'h1);
        end
        @(posedge clk); #1;
        chk("post_rec_valid", {31'h0, sum_valid}, 32'h0);
        drain("ramp");

        fill(0, 4'hF);
        push_record(8'h00, 8'hC0, 8'hF3);
        send_frame(64);
        drain("all15");

        fill(0, 4'h0);
        push_record(8'h00, 8'h00, 8'h00);
        send_frame(64);
        drain("all0");

        // Short frame: 11 beats of 2
        fill(0, 4'h2);
        push_record(8'h80, 8'h16, 8'h20);
        send_frame(11);
        chk("short_frame_err", {31'h0, frame_err}, 32'h1);
        chk("short_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        chk("short_err_pulse_end", {31'h0, frame_err}, 32'h0);
        drain("short");

        // Overlong: 64 ones, then a 15 without last and a 15 with last (neither accumulated)
        fill(0, 4'h1);
        frame_vals[64] = 4'hF;
        frame_vals[65] = 4'hF;
        push_record(8'h80, 8'h40, 8'h10);
        send_frame(66);
        chk("long_frame_err", {31'h0, frame_err}, 32'h1);
        drain("overlong");

        // Stalled downstream on the ramp frame
        ready_mode = 1;
        fill(1, 4'h0);
        push_record(8'h0F, 8'hE0, 8'hF1);
        send_frame(64);
        drain("stall");

        // Drops during emission flag only the following record
        fill(0, 4'h1);
        push_record(8'h00, 8'h40, 8'h10);
        send_frame(64);
        chk("drop_busy", {31'h0, busy}, 32'h1);
        bin_valid = 1'b1; bin_last = 1'b1; bin_data = 4'hF;
        @(posedge clk); #1;
        bin_valid = 1'b0; bin_last = 1'b0;
        @(posedge clk); #1;
        bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_valid = 1'b0;
        drain("drop_cur");
        push_record(8'h40, 8'h40, 8'h10);
        send_frame(64);
        drain("drop_next");
        push_record(8'h00, 8'h40, 8'h10);
        send_frame(64);
        drain("drop_cleared");

        // Async reset after B1 is accepted
        push_record(8'h00, 8'h40, 8'h10);
        send_frame(64);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                if (exp_q.size() <= REC_LEN - 2) break;
                @(posedge clk); #1;
            end
            checks++;
            if (k == 100) begin
                errors++;
                $display("FAIL reset_wait timeout actual=%0d expected=%0d", exp_q.size(), REC_LEN - 2);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, sum_valid}, 32'h0);
        chk("async_rst_outs", {22'h0, sum_byte, sum_first, sum_last}, 32'h0);
        chk("async_rst_busy", {30'h0, busy, frame_err}, 32'h0);
        exp_q.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill(0, 4'h0);
        push_record(8'h00, 8'h00, 8'h00);
        send_frame(64);
        chk("post_rst_b0", {24'h0, sum_byte}, 32'hA5);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
